ps2_key_decoder: RTL
====================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000: CLOCK_50 cycles (1 ms) allowed between PS2_KBCLK falling edges within a frame.
REQ-002 SHALL have port CLOCK_50  input  1  system clock; the only clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port PS2_KBCLK  input  1  keyboard clock, asynchronous.
REQ-005 SHALL have port PS2_KBDAT  input  1  keyboard data, asynchronous.
REQ-006 SHALL have port ascii  output  7  code of the held key; 0 = no key (downstream treats 0 as silence).
REQ-007 SHALL have port key_valid  output  1  high while ascii is non-zero.
REQ-008 SHALL have port key_strobe  output  1  one-cycle pulse when ascii changes to a new non-zero value.
REQ-009 SHALL have port frame_error  output  1  one-cycle pulse when a frame is discarded.

Function
REQ-010 SHALL pass PS2_KBCLK and PS2_KBDAT through 2-flop synchronisers; a falling edge is synced clock 1 then 0 on consecutive cycles.
REQ-011 SHALL have frame FSM states IDLE, DATA, PARITY, STOP, with one transition per falling edge.
REQ-012 IDLE: a falling edge with data 0 goes to DATA with bit count 0; data 1 stays in IDLE and pulses frame_error.
REQ-013 DATA: SHALL shift 8 bits LSB first, then go to PARITY after bit 7.
REQ-014 PARITY: SHALL capture the bit and go to STOP; a byte is good only if the 8 data bits plus parity contain an odd number of ones.
REQ-015 STOP: SHALL return to IDLE; with stop bit 1 and good parity, the byte is accepted; otherwise frame_error pulses and the byte is dropped.
REQ-016 Outside IDLE, SHALL count cycles since the last falling edge; on reaching TIMEOUT_CYCLES it SHALL go to IDLE, pulse frame_error and drop partial data.
REQ-017 Byte 0xE0 SHALL set the extended flag; byte 0xF0 SHALL set the break flag; both flags clear after the next non-prefix byte.
REQ-018 A non-prefix byte with the extended flag set SHALL be ignored.
REQ-019 Scancode map: 0x1C..letters A–Z to 0x41–0x5A (standard set-2), digits to 0x30–0x39, 0x29 to 0x20; all other codes are ignored.
REQ-020 A mapped make code differing from the current ascii SHALL load ascii and pulse key_strobe in the same cycle, one cycle after the accepted stop edge.
REQ-021 A make code equal to the current ascii (typematic repeat) SHALL cause no change and no strobe.
REQ-022 A break whose mapped code equals the current ascii SHALL clear ascii to 0 one cycle after the stop edge; a break for any other key SHALL be ignored.
REQ-023 A frame error SHALL clear the extended and break flags but leave ascii unchanged.
REQ-024 key_strobe and frame_error SHALL never be asserted for more than one cycle per event.

Reset
REQ-025 Reset SHALL force FSM IDLE, counters 0, flags 0, synchronisers to 1, ascii 0, key_valid 0, key_strobe 0, frame_error 0.
REQ-026 Reset mid-frame SHALL discard the frame; decoding resumes at the next start bit after reset deasserts.

Structure
REQ-027 Package ps2_pkg SHALL hold the FSM state typedef, the constants 0xE0 and 0xF0, and the ascii width 7.
REQ-028 The scancode-to-ascii table SHALL be a combinational sub-module ps2_scan_to_ascii: 8-bit code in; 7-bit ascii plus a mapped flag out.

Verification
REQ-029 Frame 0x1C, parity 0 -> ascii 0x41, key_valid 1, one key_strobe pulse one cycle after the stop edge.
REQ-030 0x1C, 0x1C, 0xF0, 0x1C -> exactly one strobe; ascii returns to 0x00 after the break.
REQ-031 0x1C with parity 1 -> one frame_error pulse; ascii stays 0x00; then a good 0x32 -> ascii 0x42.
REQ-032 5 bits then idle -> frame_error after 50000 cycles, FSM in IDLE; then 0x32 decodes to 0x42.
REQ-033 Sequence 0x1C, then 0xE0 0x75, then 0xE0 0xF0 0x75 -> ascii stays 0x41 throughout, with no strobe after the first.
REQ-034 Reset asserted at data bit 4 of 0x1C -> all outputs 0; the following full 0x1C frame decodes to 0x41.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard decoder.
// Frame FSM state encoding, scancode prefix bytes and ascii width.
// No ports; imported by ps2_key_decoder and ps2_scan_to_ascii.
package ps2_pkg;

    localparam int ASCII_W = 7;

    localparam logic [7:0] SC_EXTENDED = 8'hE0;
    localparam logic [7:0] SC_BREAK    = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// Set-2 scancode to ascii lookup, purely combinational (zero latency).
// Ports: code_i (8-bit scancode) -> ascii_o (7-bit code), mapped_o (code is in the table).
// No backpressure; unmapped codes give ascii_o = 0 and mapped_o = 0.
module ps2_scan_to_ascii
    import ps2_pkg::*;
(
    input  logic [7:0]         code_i,
    output logic [ASCII_W-1:0] ascii_o,
    output logic               mapped_o
);

    always_comb begin
        ascii_o  = '0;
        mapped_o = 1'b1;
        case (code_i)
            // letters
            8'h1C: ascii_o = 7'h41; // A
            8'h32: ascii_o = 7'h42; // B
            8'h21: ascii_o = 7'h43; // C
            8'h23: ascii_o = 7'h44; // D
            8'h24: ascii_o = 7'h45; // E
            8'h2B: ascii_o = 7'h46; // F
            8'h34: ascii_o = 7'h47; // G
            8'h33: ascii_o = 7'h48; // H
            8'h43: ascii_o = 7'h49; // I
            8'h3B: ascii_o = 7'h4A; // J
            8'h42: ascii_o = 7'h4B; // K
            8'h4B: ascii_o = 7'h4C; // L
            8'h3A: ascii_o = 7'h4D; // M
            8'h31: ascii_o = 7'h4E; // N
            8'h44: ascii_o = 7'h4F; // O
            8'h4D: ascii_o = 7'h50; // P
            8'h15: ascii_o = 7'h51; // Q
            8'h2D: ascii_o = 7'h52; // R
            8'h1B: ascii_o = 7'h53; // S
            8'h2C: ascii_o = 7'h54; // T
            8'h3C: ascii_o = 7'h55; // U
            8'h2A: ascii_o = 7'h56; // V
            8'h1D: ascii_o = 7'h57; // W
            8'h22: ascii_o = 7'h58; // X
            8'h35: ascii_o = 7'h59; // Y
            8'h1A: ascii_o = 7'h5A; // Z
            // digits (main row)
            8'h45: ascii_o = 7'h30;
            8'h16: ascii_o = 7'h31;
            8'h1E: ascii_o = 7'h32;
            8'h26: ascii_o = 7'h33;
            8'h25: ascii_o = 7'h34;
            8'h2E: ascii_o = 7'h35;
            8'h36: ascii_o = 7'h36;
            8'h3D: ascii_o = 7'h37;
            8'h3E: ascii_o = 7'h38;
            8'h46: ascii_o = 7'h39;
            // space bar
            8'h29: ascii_o = 7'h20;
            default: mapped_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frames bytes, tracks E0/F0 prefixes, reports the held key as ascii.
// Ports: CLOCK_50/reset; PS2_KBCLK/PS2_KBDAT async inputs; ascii, key_valid, key_strobe, frame_error.
// Latency: outputs update one cycle after the synchronised stop edge; no backpressure (keyboard is free-running).
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               PS2_KBCLK,
    input  logic               PS2_KBDAT,
    output logic [ASCII_W-1:0] ascii,
    output logic               key_valid,
    output logic               key_strobe,
    output logic               frame_error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchronisers; everything resets to 1 (idle line level) so reset
    // release never manufactures a falling edge.
    // ------------------------------------------------------------------
    logic kbclk_meta_q, kbclk_sync_q, kbclk_prev_q;
    logic kbdat_meta_q, kbdat_sync_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            kbclk_meta_q <= 1'b1;
            kbclk_sync_q <= 1'b1;
            kbclk_prev_q <= 1'b1;
            kbdat_meta_q <= 1'b1;
            kbdat_sync_q <= 1'b1;
        end else begin
            kbclk_meta_q <= PS2_KBCLK;
            kbclk_sync_q <= kbclk_meta_q;
            kbclk_prev_q <= kbclk_sync_q;
            kbdat_meta_q <= PS2_KBDAT;
            kbdat_sync_q <= kbdat_meta_q;
        end
    end

    logic fall;
    assign fall = kbclk_prev_q & ~kbclk_sync_q;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    ps2_state_e       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout;

    // A falling edge on the very cycle the count expires wins: the bit is
    // taken rather than the frame discarded.
    assign timeout = (state_q != ST_IDLE) && !fall && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_cnt_d = '0;
        if (timeout) begin
            state_d = ST_IDLE;
        end else if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!kbdat_sync_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {kbdat_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = kbdat_sync_q;
                    state_d = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Frame-level results: byte_ok on a clean stop, frame_err on a bad
    // start bit, bad parity/stop, or inter-edge timeout.
    logic byte_ok, frame_err;

    always_comb begin
        byte_ok   = 1'b0;
        frame_err = timeout;
        if (fall) begin
            case (state_q)
                ST_IDLE: frame_err = kbdat_sync_q;
                ST_STOP: begin
                    if (kbdat_sync_q && (^{shift_q, par_q})) begin
                        byte_ok = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Key tracking
    // ------------------------------------------------------------------
    logic [ASCII_W-1:0] map_code;
    logic               map_hit;

    ps2_scan_to_ascii u_scan (
        .code_i   (shift_q),
        .ascii_o  (map_code),
        .mapped_o (map_hit)
    );

    logic [ASCII_W-1:0] ascii_q, ascii_d;
    logic               ext_q, ext_d;
    logic               brk_q, brk_d;
    logic               strobe_q, strobe_d;
    logic               ferr_q;

    always_comb begin
        ascii_d  = ascii_q;
        ext_d    = ext_q;
        brk_d    = brk_q;
        strobe_d = 1'b0;
        if (frame_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_ok) begin
            if (shift_q == SC_EXTENDED) begin
                ext_d = 1'b1;
            end else if (shift_q == SC_BREAK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                // Extended keys (arrows etc.) have no ascii here, so both
                // their make and break codes are dropped.
                if (!ext_q && map_hit) begin
                    if (brk_q) begin
                        if (map_code == ascii_q) begin
                            ascii_d = '0;
                        end
                    end else if (map_code != ascii_q) begin
                        ascii_d  = map_code;
                        strobe_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            ascii_q  <= '0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            strobe_q <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            ascii_q  <= ascii_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            strobe_q <= strobe_d;
            ferr_q   <= frame_err;
        end
    end

    assign ascii       = ascii_q;
    assign key_valid   = (ascii_q != '0);
    assign key_strobe  = strobe_q;
    assign frame_error = ferr_q;

endmodule
